// File: rtl/mem_request_proxy_n.sv
// mem_request_proxy_n: arbitrates NCH datapath request channels onto a single
// cache-side memory port. One access is in flight at a time; REN/WEN and the
// address/store data are registered and held stable until the cache hits or
// the watchdog expires, then a one-cycle done pulse (with err) is returned on
// the owning channel.
//
// Handshake: a client raises req[i] with wen/addr/wdata stable and keeps them
// stable until done[i] pulses; done is one-hot or zero, err and rdata are
// valid in the done cycle, and rdata holds until the next completed read.
module mem_request_proxy_n #(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    wen,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    done,
    output logic              err,
    output logic [DW-1:0]     rdata,
    output logic              memREN,
    output logic              memWEN,
    output logic [AW-1:0]     memaddr,
    output logic [DW-1:0]     memstore,
    input  logic [DW-1:0]     memload,
    input  logic              hit,
    input  logic              halt,
    output logic              halted,
    output logic              timeout_sticky,
    output logic [1:0]        dbg_state
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PW-1:0] LAST_CH = PW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [NCH-1:0]  done_q, done_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            ren_q, ren_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   maddr_q, maddr_d;
    logic [DW-1:0]   mstore_q, mstore_d;
    logic            halted_q, halted_d;
    logic            sticky_q, sticky_d;

    logic [NCH-1:0]  eligible;
    logic            lo_any, hi_any, grant_any;
    logic [PW-1:0]   lo_idx, hi_idx, grant_idx;
    logic            sel_wen;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [NCH-1:0]  owner_hot;
    logic            expire;

    // Arbitration: the channel completed last cycle is masked so it cannot be
    // re-granted on a request it has not yet had a chance to drop.
    always_comb begin
        eligible = req & ~done_q;
        lo_any   = 1'b0;
        lo_idx   = '0;
        hi_any   = 1'b0;
        hi_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lo_any = 1'b1;
                lo_idx = PW'(i);
                if (PW'(i) >= rr_ptr_q) begin
                    hi_any = 1'b1;
                    hi_idx = PW'(i);
                end
            end
        end
        grant_any = lo_any;
        grant_idx = ((RR_MODE != 0) && hi_any) ? hi_idx : lo_idx;
    end

    // Operand mux for the granted channel and one-hot decode of the owner.
    always_comb begin
        sel_wen   = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        owner_hot = '0;
        for (int i = 0; i < NCH; i++) begin
            if (PW'(i) == grant_idx) begin
                sel_wen   = wen[i];
                sel_addr  = addr[i*AW +: AW];
                sel_wdata = wdata[i*DW +: DW];
            end
            owner_hot[i] = (PW'(i) == owner_q);
        end
        expire = (TIMEOUT != 0) && (wdog_q == WD_LAST);
    end

    // Next-state logic for the IDLE / ISSUE / HALT controller.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        wdog_d   = wdog_q;
        done_d   = '0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        maddr_d  = maddr_q;
        mstore_d = mstore_q;
        halted_d = halted_q;
        sticky_d = sticky_q;
        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                    ren_d    = 1'b0;
                    wen_d    = 1'b0;
                end else if (grant_any) begin
                    state_d  = ISSUE;
                    owner_d  = grant_idx;
                    maddr_d  = sel_addr;
                    mstore_d = sel_wdata;
                    ren_d    = ~sel_wen;
                    wen_d    = sel_wen;
                    wdog_d   = '0;
                    if (RR_MODE != 0) begin
                        rr_ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (hit) begin
                    // A hit in the watchdog expiry cycle still completes normally.
                    state_d = IDLE;
                    done_d  = owner_hot;
                    if (!wen_q) begin
                        rdata_d = memload;
                    end
                    ren_d = 1'b0;
                    wen_d = 1'b0;
                end else if (expire) begin
                    state_d  = IDLE;
                    done_d   = owner_hot;
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                    ren_d    = 1'b0;
                    wen_d    = 1'b0;
                end else if (TIMEOUT != 0) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            HALT: begin
                ren_d = 1'b0;
                wen_d = 1'b0;
                if (!halt) begin
                    state_d  = IDLE;
                    halted_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                halted_d = 1'b0;
                ren_d    = 1'b0;
                wen_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wdog_q   <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            maddr_q  <= '0;
            mstore_q <= '0;
            halted_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            wdog_q   <= wdog_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            maddr_q  <= maddr_d;
            mstore_q <= mstore_d;
            halted_q <= halted_d;
            sticky_q <= sticky_d;
        end
    end

    assign done           = done_q;
    assign err            = err_q;
    assign rdata          = rdata_q;
    assign memREN         = ren_q;
    assign memWEN         = wen_q;
    assign memaddr        = maddr_q;
    assign memstore       = mstore_q;
    assign halted         = halted_q;
    assign timeout_sticky = sticky_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_request_proxy_n.sv
// Directed bench for mem_request_proxy_n: a 2-channel fixed-priority instance
// with a 4-cycle watchdog, and a 3-channel round-robin instance.
module tb_mem_request_proxy_n;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    // Instance A: NCH=2, fixed priority, TIMEOUT=4
    logic [1:0]  a_req = '0, a_wen = '0, a_done;
    logic [63:0] a_addr = '0, a_wdata = '0;
    logic        a_err, a_ren, a_wenm, a_hit = 1'b0, a_halt = 1'b0, a_halted, a_sticky;
    logic [31:0] a_rdata, a_maddr, a_mstore, a_mload = '0;
    logic [1:0]  a_dbg;

    // Instance B: NCH=3, round-robin, no watchdog
    logic [2:0]  b_req = '0, b_wen = '0, b_done;
    logic [95:0] b_addr = '0, b_wdata = '0;
    logic        b_err, b_ren, b_wenm, b_hit = 1'b0, b_halt = 1'b0, b_halted, b_sticky;
    logic [31:0] b_rdata, b_maddr, b_mstore, b_mload = '0;
    logic [1:0]  b_dbg;

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] exp_rd_q[$];

    // Clock and reset block
    always #5 CLK = ~CLK;

    mem_request_proxy_n #(.NCH(2), .AW(32), .DW(32), .RR_MODE(0), .TIMEOUT(4)) dut_a (
        .CLK(CLK), .RST(RST), .req(a_req), .wen(a_wen), .addr(a_addr), .wdata(a_wdata),
        .done(a_done), .err(a_err), .rdata(a_rdata), .memREN(a_ren), .memWEN(a_wenm),
        .memaddr(a_maddr), .memstore(a_mstore), .memload(a_mload), .hit(a_hit),
        .halt(a_halt), .halted(a_halted), .timeout_sticky(a_sticky), .dbg_state(a_dbg)
    );

    mem_request_proxy_n #(.NCH(3), .AW(32), .DW(32), .RR_MODE(1), .TIMEOUT(0)) dut_b (
        .CLK(CLK), .RST(RST), .req(b_req), .wen(b_wen), .addr(b_addr), .wdata(b_wdata),
        .done(b_done), .err(b_err), .rdata(b_rdata), .memREN(b_ren), .memWEN(b_wenm),
        .memaddr(b_maddr), .memstore(b_mstore), .memload(b_mload), .hit(b_hit),
        .halt(b_halt), .halted(b_halted), .timeout_sticky(b_sticky), .dbg_state(b_dbg)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        tick();
        tick();
        check_val("rst_done",   64'(a_done), 64'h0);
        check_val("rst_ren",    64'(a_ren), 64'h0);
        check_val("rst_wen",    64'(a_wenm), 64'h0);
        check_val("rst_rdata",  64'(a_rdata), 64'h0);
        check_val("rst_maddr",  64'(a_maddr), 64'h0);
        check_val("rst_halted", 64'(a_halted), 64'h0);
        check_val("rst_sticky", 64'(a_sticky), 64'h0);
        check_val("rst_b_done", 64'(b_done), 64'h0);
        RST = 1'b0;
        tick();

        // ---------------- single read on ch1 ----------------
        a_req  = 2'b10;
        a_wen  = 2'b00;
        a_addr = {32'h0000_0040, 32'h0000_0000};
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_val("rd_ren", 64'(a_ren), 64'h1);
            check_val("rd_maddr", 64'(a_maddr), 64'h40);
            check_val("rd_no_done", 64'(a_done), 64'h0);
        end
        a_hit   = 1'b1;
        a_mload = 32'hDEAD_BEEF;
        tick();
        check_val("rd_done", 64'(a_done), 64'h2);
        check_val("rd_err", 64'(a_err), 64'h0);
        check_val("rd_rdata", 64'(a_rdata), 64'hDEAD_BEEF);
        check_val("rd_ren_drop", 64'(a_ren), 64'h0);
        a_hit = 1'b0;
        a_req = 2'b00;
        tick();
        check_val("rd_done_once", 64'(a_done), 64'h0);
        check_val("rd_rdata_hold", 64'(a_rdata), 64'hDEAD_BEEF);

        // ---------------- fixed priority: ch0 read, ch1 write ----------------
        exp_q    = {8'h01, 8'h02, 8'h01};
        exp_rd_q = {32'h55, 32'h55, 32'h66};
        a_req   = 2'b11;
        a_wen   = 2'b10;
        a_addr  = {32'h0000_0104, 32'h0000_0100};
        a_wdata = {32'h0000_BBBB, 32'h0000_AAAA};
        a_mload = 32'h55;
        a_hit   = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            tick();
            check_val("fx_excl", 64'(a_ren & a_wenm), 64'h0);
            if (a_done != 2'b00) begin
                check_val("fx_order", 64'(a_done), 64'(exp_q.pop_front()));
                check_val("fx_rdata", 64'(a_rdata), 64'(exp_rd_q.pop_front()));
                a_mload = 32'h66;
            end
        end
        check_val("fx_bound", 64'(exp_q.size()), 64'h0);
        a_req = 2'b00;
        a_hit = 1'b0;
        tick();

        // ---------------- round-robin, 3 channels ----------------
        exp_q  = {8'h01, 8'h02, 8'h04, 8'h01};
        b_req  = 3'b111;
        b_hit  = 1'b1;
        b_mload = 32'h77;
        for (int c = 0; c < 24 && exp_q.size() > 0; c++) begin
            tick();
            check_val("rr_excl", 64'(b_ren & b_wenm), 64'h0);
            if (b_done != 3'b000) begin
                check_val("rr_order", 64'(b_done), 64'(exp_q.pop_front()));
            end
        end
        check_val("rr_bound", 64'(exp_q.size()), 64'h0);
        b_req = 3'b000;
        b_hit = 1'b0;

        // ---------------- write with watchdog timeout ----------------
        a_req   = 2'b01;
        a_wen   = 2'b01;
        a_addr  = {32'h0, 32'h0000_0080};
        a_wdata = {32'h0, 32'h0000_1234};
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_val("to_wen", 64'(a_wenm), 64'h1);
            check_val("to_ren", 64'(a_ren), 64'h0);
            check_val("to_mstore", 64'(a_mstore), 64'h1234);
            check_val("to_maddr", 64'(a_maddr), 64'h80);
            check_val("to_no_done", 64'(a_done), 64'h0);
        end
        tick();
        check_val("to_done", 64'(a_done), 64'h1);
        check_val("to_err", 64'(a_err), 64'h1);
        check_val("to_sticky", 64'(a_sticky), 64'h1);
        check_val("to_wen_drop", 64'(a_wenm), 64'h0);
        check_val("to_rdata_hold", 64'(a_rdata), 64'h66);
        a_req = 2'b00;
        tick();
        check_val("to_err_clear", 64'(a_err), 64'h0);
        check_val("to_sticky_hold", 64'(a_sticky), 64'h1);

        // ---------------- halt drain ----------------
        a_req  = 2'b10;
        a_wen  = 2'b00;
        a_addr = {32'h0000_0040, 32'h0000_0200};
        tick();
        check_val("hd_ren", 64'(a_ren), 64'h1);
        a_halt = 1'b1;
        tick();
        check_val("hd_ren_held", 64'(a_ren), 64'h1);
        a_hit   = 1'b1;
        a_mload = 32'hA5A5_A5A5;
        tick();
        check_val("hd_done", 64'(a_done), 64'h2);
        check_val("hd_rdata", 64'(a_rdata), 64'hA5A5_A5A5);
        a_hit = 1'b0;
        a_req = 2'b01;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("hd_halted", 64'(a_halted), 64'h1);
            check_val("hd_state", 64'(a_dbg), 64'h2);
            check_val("hd_no_ren", 64'(a_ren), 64'h0);
            check_val("hd_no_done", 64'(a_done), 64'h0);
        end
        a_halt = 1'b0;
        tick();
        check_val("hd_release", 64'(a_halted), 64'h0);
        check_val("hd_idle_ren", 64'(a_ren), 64'h0);
        tick();
        check_val("hd_grant", 64'(a_ren), 64'h1);
        check_val("hd_grant_addr", 64'(a_maddr), 64'h200);
        a_hit   = 1'b1;
        a_mload = 32'h0000_3C3C;
        tick();
        check_val("hd_done2", 64'(a_done), 64'h1);
        check_val("hd_rdata2", 64'(a_rdata), 64'h3C3C);
        a_hit = 1'b0;
        a_req = 2'b00;
        tick();

        // ---------------- reset mid-access ----------------
        a_req  = 2'b01;
        a_wen  = 2'b00;
        a_addr = {32'h0, 32'h0000_0300};
        tick();
        check_val("rm_ren", 64'(a_ren), 64'h1);
        tick();
        RST = 1'b1;
        tick();
        check_val("rm_ren", 64'(a_ren), 64'h0);
        check_val("rm_done", 64'(a_done), 64'h0);
        check_val("rm_rdata", 64'(a_rdata), 64'h0);
        check_val("rm_maddr", 64'(a_maddr), 64'h0);
        check_val("rm_sticky", 64'(a_sticky), 64'h0);
        check_val("rm_state", 64'(a_dbg), 64'h0);
        RST   = 1'b0;
        a_req = 2'b00;
        a_hit = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check_val("rm_never_done", 64'(a_done), 64'h0);
        end
        a_hit = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_request_proxy_n.md
Name: mem_request_proxy_n

Overview:
- Parametrised successor to the single-cycle datapath's request proxy: arbitrates N datapath request channels (e.g. IF, MEM stages of a pipeline) onto one cache-side memory port.
- Holds REN/WEN stable until the cache hit, returns registered load data plus a one-cycle done pulse per channel, and adds fixed/round-robin arbitration, a watchdog timeout and halt draining.
- Sits between the datapath stages and the datapath_cache_if signals.

Parameters:
- NCH, 2, number of request channels (1..8); channel 0 is highest priority in fixed mode.
- AW, 32, address width.
- DW, 32, data width.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, 0, cycles to wait for hit before abort; 0 disables the watchdog.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- req  in  NCH  per-channel request; client holds it with wen/addr/wdata stable until its done.
- wen  in  NCH  per-channel write (1) / read (0).
- addr  in  NCH*AW  packed addresses; channel i at [i*AW +: AW].
- wdata  in  NCH*DW  packed store data.
- done  out  NCH  one-cycle completion pulse, one-hot or zero.
- err  out  1  valid with done; 1 = completion was a timeout abort.
- rdata  out  DW  load data, valid in the done cycle and held until the next done.
- memREN  out  1  cache read enable.
- memWEN  out  1  cache write enable.
- memaddr  out  AW  cache address.
- memstore  out  DW  cache store data.
- memload  in  DW  cache load data.
- hit  in  1  cache completion for the current access.
- halt  in  1  stop granting new requests.
- halted  out  1  high when halt is set and no access is in flight.
- timeout_sticky  out  1  set on any timeout; cleared only by RST.

Behaviour:
- Reset (RST high at a rising edge): state=IDLE; done=0, err=0, rdata=0, memREN=memWEN=0, memaddr=0, memstore=0, halted=0, timeout_sticky=0, RR pointer=0, watchdog=0. Reset mid-access abandons it with no done pulse.
- FSM states: IDLE, ISSUE, HALT.
- IDLE:
  - Grant eligible = req & ~done_mask, where done_mask is the previous cycle's done (blocks re-issue of a just-completed client).
  - If halt: go to HALT.
  - Else if any eligible: latch owner, addr, wdata and wen into output registers; go to ISSUE.
  - Fixed mode: lowest eligible index wins.
  - RR mode: first eligible index at or after the pointer, modulo NCH; the pointer becomes owner+1 (wraps NCH-1 to 0) on grant.
- ISSUE:
  - memREN = ~wen_latched, memWEN = wen_latched; memaddr/memstore come from the latch, stable every cycle until exit.
  - On hit: done[owner]=1 and err=0 next cycle; rdata <= memload for reads (held for writes); REN/WEN drop in the same edge; go IDLE.
- Latency: grant edge to first REN/WEN = 1 cycle. Hit to done = 1 cycle. Minimum back-to-back per channel is 3 cycles; a different channel can be granted in the done cycle.
- Watchdog (TIMEOUT>0):
  - Counts cycles in ISSUE without a hit.
  - When the count reaches TIMEOUT with no hit: drop REN/WEN; done[owner]=1, err=1 and timeout_sticky=1 next cycle; rdata unchanged; go IDLE.
  - A hit in the expiry cycle wins: normal completion, err=0.
  - Counter clears on entry to ISSUE.
- Halt:
  - Sampled only in IDLE; an in-flight ISSUE always completes (or times out) first.
  - In HALT: no grants, REN/WEN=0, halted=1. Leaving HALT needs halt=0, then go IDLE; halted drops the same edge.
- Client dropping req during ISSUE does not abort the access; done still pulses.
- NCH=1: arbitration degenerates and the RR pointer stays 0.
- memREN and memWEN are never both 1.

Test Plan:
- Single read: NCH=2, req[1]=1, wen=0, addr[1]=0x40; hit at 3rd ISSUE cycle with memload=0xDEADBEEF -> memREN=1 for 3 cycles, memaddr=0x40; done=2'b10, rdata=0xDEADBEEF one cycle after hit.
- Fixed priority: RR_MODE=0, req=2'b11 persistently, hit after 1 cycle each -> grant order ch0,ch1 (ch0 masked only in its done cycle); no cycle with REN and WEN both high.
- Round-robin: RR_MODE=1, NCH=3, req=3'b111 held -> grants 0,1,2,0 with pointer wrap 2->0.
- Write then timeout: TIMEOUT=4, ch0 write addr 0x80 wdata 0x1234, no hit -> memWEN=1 for 4 cycles, memstore=0x1234; then done=01, err=1, timeout_sticky=1, rdata unchanged.
- Halt drain: assert halt during ISSUE -> access completes with done; next state HALT, halted=1, pending req ignored; deassert halt -> pending req granted next cycle.
- Reset mid-access: RST in the 2nd ISSUE cycle -> next cycle memREN=0, done=0, all outputs at reset values, and no done pulse ever for the abandoned request.
